// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the simple register/ALU datapath: latches an instruction,
// walks it through decode/operand/execute/write-back states and drives datapath enables.
module datapath_ctrl #(
    parameter int STATUS_ON_ALL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        waiting,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  r_addr,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic        en_A,
    output logic        en_B,
    output logic        en_C,
    output logic        en_status,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  ALU_op,
    output logic [1:0]  shift_op,
    output logic [1:0]  wb_sel,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_IMM,
        S_WR_REG
    } state_t;

    typedef struct packed {
        logic       waiting;
        logic       done;
        logic       illegal;
        logic [2:0] rAddr;
        logic [2:0] wAddr;
        logic       wEn;
        logic       enA;
        logic       enB;
        logic       enC;
        logic       enStatus;
        logic       selA;
        logic       selB;
        logic [1:0] aluOp;
        logic [1:0] shiftOp;
        logic [1:0] wbSel;
    } ctrl_t;

    state_t      r_state;
    logic [15:0] r_ir;
    ctrl_t       r_ctrl;

    state_t      w_nextState;
    logic [15:0] w_nextIr;
    logic        w_isAlu;
    logic        w_isMovImm;
    logic        w_isMovReg;

    // Control word for a given state and IR; registered so outputs stay glitch-free
    // while still matching the state they describe.
    function automatic ctrl_t decodeCtrl(input state_t s, input logic [15:0] ir);
        ctrl_t c;
        logic  isAlu;
        logic  isMovImm;
        logic  isMovReg;
        logic  isCmp;
        logic  isMvn;
        c        = '0;
        isAlu    = (ir[15:13] == 3'b101);
        isMovImm = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
        isMovReg = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
        isCmp    = isAlu && (ir[12:11] == 2'b01);
        isMvn    = isAlu && (ir[12:11] == 2'b11);
        case (s)
            S_WAIT:   c.waiting = 1'b1;
            S_DECODE: c.illegal = !(isAlu || isMovImm || isMovReg);
            S_GET_A: begin
                c.rAddr = ir[10:8];
                c.enA   = 1'b1;
            end
            S_GET_B: begin
                c.rAddr = ir[2:0];
                c.enB   = 1'b1;
            end
            S_EXEC: begin
                c.enC      = 1'b1;
                c.shiftOp  = ir[4:3];
                c.aluOp    = isAlu ? ir[12:11] : 2'b00;
                c.selA     = isMovReg || isMvn;
                c.enStatus = isCmp || (STATUS_ON_ALL != 0);
                c.done     = isCmp;
            end
            S_WR_IMM: begin
                c.wEn   = 1'b1;
                c.wAddr = ir[10:8];
                c.wbSel = 2'b10;
                c.done  = 1'b1;
            end
            S_WR_REG: begin
                c.wEn   = 1'b1;
                c.wAddr = ir[7:5];
                c.wbSel = 2'b00;
                c.done  = 1'b1;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign w_isAlu    = (r_ir[15:13] == 3'b101);
    assign w_isMovImm = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b10);
    assign w_isMovReg = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b00);

    always_comb begin
        w_nextState = r_state;
        w_nextIr    = r_ir;
        case (r_state)
            S_WAIT: begin
                if (start) begin
                    w_nextState = S_DECODE;
                    w_nextIr    = instr;
                end
            end
            S_DECODE: begin
                if (w_isMovImm)
                    w_nextState = S_WR_IMM;
                else if (w_isAlu && (r_ir[12:11] != 2'b11))
                    w_nextState = S_GET_A;
                else if (w_isMovReg || w_isAlu)
                    w_nextState = S_GET_B;
                else
                    w_nextState = S_WAIT;
            end
            S_GET_A:  w_nextState = S_GET_B;
            S_GET_B:  w_nextState = S_EXEC;
            // CMP only updates status, so it finishes in EXEC without a write-back.
            S_EXEC:   w_nextState = (w_isAlu && (r_ir[12:11] == 2'b01)) ? S_WAIT : S_WR_REG;
            S_WR_IMM: w_nextState = S_WAIT;
            S_WR_REG: w_nextState = S_WAIT;
            default:  w_nextState = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_ctrl  <= decodeCtrl(S_WAIT, 16'h0000);
        end else begin
            r_state <= w_nextState;
            r_ir    <= w_nextIr;
            r_ctrl  <= decodeCtrl(w_nextState, w_nextIr);
        end
    end

    assign waiting   = r_ctrl.waiting;
    assign done      = r_ctrl.done;
    assign illegal   = r_ctrl.illegal;
    assign r_addr    = r_ctrl.rAddr;
    assign w_addr    = r_ctrl.wAddr;
    assign w_en      = r_ctrl.wEn;
    assign en_A      = r_ctrl.enA;
    assign en_B      = r_ctrl.enB;
    assign en_C      = r_ctrl.enC;
    assign en_status = r_ctrl.enStatus;
    assign sel_A     = r_ctrl.selA;
    assign sel_B     = r_ctrl.selB;
    assign ALU_op    = r_ctrl.aluOp;
    assign shift_op  = r_ctrl.shiftOp;
    assign wb_sel    = r_ctrl.wbSel;
    assign sximm8    = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5    = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: walks each instruction class state by state against
// hand-computed control words, plus reset, illegal and stray-start cases.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic        waiting, done, illegal;
    logic [2:0]  r_addr, w_addr;
    logic        w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
    logic [1:0]  ALU_op, shift_op, wb_sel;
    logic [15:0] sximm8, sximm5;

    int checkCount = 0;
    int failCount  = 0;
    bit monitorOn  = 1'b0;

    datapath_ctrl #(.STATUS_ON_ALL(0)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .waiting(waiting), .done(done), .illegal(illegal),
        .r_addr(r_addr), .w_addr(w_addr),
        .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
        .sel_A(sel_A), .sel_B(sel_B), .ALU_op(ALU_op), .shift_op(shift_op),
        .wb_sel(wb_sel), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    wire [21:0] obsVec = {waiting, done, illegal, r_addr, w_addr, w_en, en_A, en_B, en_C,
                          en_status, sel_A, sel_B, ALU_op, shift_op, wb_sel};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [21:0] ctrlVec(input logic wt, input logic dn, input logic il,
                                            input logic [2:0] ra, input logic [2:0] wa,
                                            input logic wen, input logic ena, input logic enb,
                                            input logic enc, input logic ens, input logic sla,
                                            input logic [1:0] alu, input logic [1:0] sh,
                                            input logic [1:0] wb);
        return {wt, dn, il, ra, wa, wen, ena, enb, enc, ens, sla, 1'b0, alu, sh, wb};
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic [15:0] i);
        rst   = r;
        start = s;
        instr = i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [21:0] expected);
        checkOutput(tag, {10'b0, obsVec}, {10'b0, expected});
    endtask

    // At most one of the register/pipeline load enables may be high in any cycle.
    always @(negedge clk) begin
        if (monitorOn)
            checkOutput("oneEnable", {31'b0, ($countones({w_en, en_A, en_B, en_C}) <= 1)}, 32'd1);
    end

    logic [21:0] vWait;
    logic [21:0] vIdle;

    initial begin
        vWait = ctrlVec(1, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
        vIdle = 22'd0;

        applyStimulus(1, 0, 16'h0000);
        tick();
        tick();
        monitorOn = 1'b1;
        checkState("resetWait", vWait);
        checkOutput("resetSximm8", {16'b0, sximm8}, 32'h0);
        checkOutput("resetSximm5", {16'b0, sximm5}, 32'h0);

        applyStimulus(1, 1, 16'hD201);
        tick();
        checkState("rstOverStart", vWait);
        checkOutput("rstOverStartImm8", {16'b0, sximm8}, 32'h0);

        // MOV R2,#1
        applyStimulus(0, 1, 16'hD201);
        tick();
        checkState("movImm.decode", vIdle);
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("movImm.wrImm", ctrlVec(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'b10));
        checkOutput("movImm.sximm8", {16'b0, sximm8}, 32'h0001);
        checkOutput("movImm.sximm5", {16'b0, sximm5}, 32'h0001);
        tick();
        checkState("movImm.wait", vWait);

        // ADD R5,R2,R3 with a stray start/instr change mid-instruction
        applyStimulus(0, 1, 16'hA2A3);
        tick();
        checkState("add.decode", vIdle);
        applyStimulus(0, 1, 16'hFFFF);
        tick();
        checkState("add.getA", ctrlVec(0, 0, 0, 3'b010, 3'd0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("add.getB", ctrlVec(0, 0, 0, 3'b011, 3'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        applyStimulus(0, 0, 16'hFFFF);
        tick();
        checkState("add.exec", ctrlVec(0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'd0));
        applyStimulus(0, 1, 16'hAA03);
        tick();
        checkState("add.wrReg", ctrlVec(0, 1, 0, 3'd0, 3'b101, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        tick();
        checkState("add.wait", vWait);

        // CMP R2,R3 accepted back-to-back from the WAIT cycle after done
        tick();
        checkState("cmp.decode", vIdle);
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("cmp.getA", ctrlVec(0, 0, 0, 3'b010, 3'd0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("cmp.getB", ctrlVec(0, 0, 0, 3'b011, 3'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("cmp.exec", ctrlVec(0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 0, 2'b01, 2'b00, 2'd0));
        tick();
        checkState("cmp.wait", vWait);

        // MOV R1,R4,LSL#1
        applyStimulus(0, 1, 16'hC02C);
        tick();
        checkState("movReg.decode", vIdle);
        applyStimulus(0, 0, 16'hC02C);
        tick();
        checkState("movReg.getB", ctrlVec(0, 0, 0, 3'b100, 3'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("movReg.exec", ctrlVec(0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b01, 2'd0));
        tick();
        checkState("movReg.wrReg", ctrlVec(0, 1, 0, 3'd0, 3'b001, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        checkOutput("movReg.sximm8", {16'b0, sximm8}, 32'h002C);
        checkOutput("movReg.sximm5", {16'b0, sximm5}, 32'h000C);
        tick();
        checkState("movReg.wait", vWait);

        // MVN R7,R1
        applyStimulus(0, 1, 16'hB8E1);
        tick();
        checkState("mvn.decode", vIdle);
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("mvn.getB", ctrlVec(0, 0, 0, 3'b001, 3'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("mvn.exec", ctrlVec(0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 1, 2'b11, 2'b00, 2'd0));
        checkOutput("mvn.sximm8", {16'b0, sximm8}, 32'hFFE1);
        checkOutput("mvn.sximm5", {16'b0, sximm5}, 32'h0001);
        tick();
        checkState("mvn.wrReg", ctrlVec(0, 1, 0, 3'd0, 3'b111, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        tick();
        checkState("mvn.wait", vWait);

        // AND R4,R3,R7,ASR
        applyStimulus(0, 1, 16'hB39F);
        tick();
        checkState("and.decode", vIdle);
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("and.getA", ctrlVec(0, 0, 0, 3'b011, 3'd0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("and.getB", ctrlVec(0, 0, 0, 3'b111, 3'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        tick();
        checkState("and.exec", ctrlVec(0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b11, 2'd0));
        checkOutput("and.sximm8", {16'b0, sximm8}, 32'hFF9F);
        checkOutput("and.sximm5", {16'b0, sximm5}, 32'hFFFF);
        tick();
        checkState("and.wrReg", ctrlVec(0, 1, 0, 3'd0, 3'b100, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        tick();
        checkState("and.wait", vWait);

        // Illegal opcode 111, then illegal 110/01
        applyStimulus(0, 1, 16'hE000);
        tick();
        checkState("illegal.decode", ctrlVec(0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("illegal.wait", vWait);
        applyStimulus(0, 1, 16'hC800);
        tick();
        checkState("illegal2.decode", ctrlVec(0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("illegal2.wait", vWait);

        // Reset while an ADD sits in GET_B; start is held high throughout the reset
        applyStimulus(0, 1, 16'hA2A3);
        tick();
        applyStimulus(0, 0, 16'hA2A3);
        tick();
        tick();
        checkState("rstMid.getB", ctrlVec(0, 0, 0, 3'b011, 3'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0));
        applyStimulus(1, 1, 16'hA2A3);
        tick();
        checkState("rstMid.wait", vWait);
        checkOutput("rstMid.irCleared", {16'b0, sximm8}, 32'h0);
        tick();
        checkState("rstMid.startIgnored", vWait);
        applyStimulus(0, 0, 16'h0000);
        tick();
        checkState("rstMid.noWrReg", vWait);
        tick();
        checkState("rstMid.idle", vWait);

        monitorOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have one parameter: STATUS_ON_ALL, default 0; 0 = en_status only for CMP, 1 = en_status for every EXEC.
REQ-002 The block SHALL have the following ports:
  clk  in  1  sole clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  request to execute instr; sampled only in WAIT.
  instr  in  16  instruction word; latched into internal IR on accepted start.
  waiting  out  1  high while in WAIT.
  done  out  1  one-cycle pulse in the final state of each instruction.
  illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding.
  r_addr, w_addr  out  3 each  datapath register-file read and write addresses.
  w_en, en_A, en_B, en_C, en_status  out  1 each  datapath load enables.
  sel_A, sel_B  out  1 each  ALU operand selects (sel_A=1 forces A to 0; sel_B=1 selects sximm5).
  ALU_op, shift_op  out  2 each  datapath ALU and shifter controls.
  wb_sel  out  2  write-back select: 00 C, 01 pc, 10 sximm8, 11 mdata.
  sximm8, sximm5  out  16 each  sign-extended IR[7:0] and IR[4:0], combinational from IR.

Function
REQ-003 IR fields SHALL be: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-004 Supported encodings SHALL be: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND Rd,Rn,Rm{sh}; 101/11 MVN Rd,Rm{sh}; all others SHALL be illegal.
REQ-005 States SHALL be WAIT, DECODE, GET_A, GET_B, EXEC, WR_IMM, WR_REG; outputs SHALL be Moore (decoded from state and IR only).
REQ-006 WAIT: start=1 SHALL latch instr into IR and go to DECODE; start=0 SHALL stay; start outside WAIT SHALL be ignored (no re-latch).
REQ-007 DECODE transitions: MOV imm -> WR_IMM; ADD/CMP/AND -> GET_A; MOV reg/MVN -> GET_B; illegal -> WAIT with illegal=1.
REQ-008 GET_A: r_addr=Rn, en_A=1 -> GET_B.  GET_B: r_addr=Rm, en_B=1 -> EXEC.
REQ-009 EXEC: en_C=1, sel_B=0, shift_op=sh; ALU_op=op for 101 instructions, 00 for MOV reg; sel_A=1 for MOV reg and MVN, else 0.
REQ-010 EXEC: en_status=1 for CMP, or for all instructions if STATUS_ON_ALL=1; CMP SHALL go to WAIT with done=1, others to WR_REG.
REQ-011 WR_REG: w_en=1, w_addr=Rd, wb_sel=00, done=1 -> WAIT.  WR_IMM: w_en=1, w_addr=Rn, wb_sel=10, done=1 -> WAIT.
REQ-012 Any output not driven by the current state SHALL be 0 (addresses 000, selects 0, ops 00).
REQ-013 Latency (edges from the start-accept edge to the done state) SHALL be: MOV imm 2, MOV reg/MVN 4, CMP 4, ADD/AND 5, illegal 1 (illegal pulse, no done).
REQ-014 Back-to-back: start held high in the WAIT cycle following done SHALL be accepted on the next edge; no extra idle cycle.
REQ-015 At most one enable in {w_en, en_A, en_B, en_C} SHALL be high in any cycle.

Reset
REQ-016 rst=1 at a rising edge SHALL force WAIT and clear IR to 0 regardless of state, including mid-instruction; the interrupted instruction SHALL be abandoned with no further enables.
REQ-017 While in reset and in WAIT, outputs SHALL be: waiting=1, done=0, illegal=0, all enables 0, addresses 0, wb_sel 00, ALU_op/shift_op 00, sximm8=sximm5=0.
REQ-018 rst SHALL take priority over start in the same cycle.

Verification
REQ-019 MOV imm: instr=0xD201 + start -> WR_IMM at edge 2 with w_addr=010, wb_sel=10, sximm8=0x0001, w_en=1, done=1.
REQ-020 ADD: instr=0xA2A3 -> GET_A r_addr=010, GET_B r_addr=011, EXEC ALU_op=00 en_C=1 en_status=0, WR_REG w_addr=101 w_en=1; done at edge 5.
REQ-021 CMP and MOV reg: instr=0xAA03 -> EXEC with ALU_op=01, en_status=1, done, no w_en ever; instr=0xC02C -> no GET_A, EXEC sel_A=1 shift_op=01, WR_REG w_addr=001.
REQ-022 Illegal: instr=0xE000 -> illegal=1 for exactly one cycle, back in WAIT at edge 2, no enables asserted.
REQ-023 Reset mid-op: ADD started, rst=1 during GET_B -> next cycle WAIT, waiting=1, all enables 0, no WR_REG; start ignored while rst=1.
REQ-024 Bench SHALL check REQ-015 every cycle and ignore start pulses asserted outside WAIT (instr change mid-op does not alter w_addr).
